// File: rtl/bar_pkg.sv
// Shared defaults, FSM state encoding and level-to-mask helper for the bar frame scheduler.
package bar_pkg;

    localparam int unsigned NUM_BARS_DEF = 16;
    localparam int unsigned BAR_W_DEF    = 18;
    localparam int unsigned MAG_W_DEF    = 12;

    // Level carries the 5-bit quantised magnitude plus headroom for the clamp value.
    localparam int unsigned LVL_W  = 6;
    localparam int unsigned MASK_W = 32;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PEND = 2'd1,
        SWAP = 2'd2
    } state_e;

    // Thermometer mask with the low 'level' bits set; bit 0 is the bottom segment.
    function automatic logic [MASK_W-1:0] level_to_mask(input logic [LVL_W-1:0] level);
        return (MASK_W'(1) << level) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/bar_level_decay.sv
// One bar's peak-hold step: rise instantly, fall by one segment per frame swap.
// Compiled only when BAR_PEAK_HOLD_EN is defined.
`ifdef BAR_PEAK_HOLD_EN
module bar_level_decay
    import bar_pkg::*;
#(
    parameter int unsigned BAR_W = BAR_W_DEF
) (
    input  logic [BAR_W-1:0] new_mask,
    input  logic [BAR_W-1:0] cur_mask,
    output logic [BAR_W-1:0] next_mask_c
);

    // Thermometer masks order the same way as their levels, and one level below a
    // higher current level can never drop under the new level.
    assign next_mask_c = (new_mask >= cur_mask) ? new_mask : (cur_mask >> 1);

endmodule
`endif

// File: rtl/bar_frame_scheduler.sv
// Collects one frame of magnitudes into a shadow buffer and swaps it onto the bar
// outputs on a vsync falling edge. Optional peak-hold decay: BAR_PEAK_HOLD_EN.
module bar_frame_scheduler
    import bar_pkg::*;
#(
    parameter int unsigned NUM_BARS = NUM_BARS_DEF,
    parameter int unsigned BAR_W    = BAR_W_DEF,
    parameter int unsigned MAG_W    = MAG_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mag_valid,
    output logic                      mag_ready,
    input  logic [MAG_W-1:0]          mag_data,
    input  logic                      mag_last,
    input  logic                      vsync,
    output logic [NUM_BARS*BAR_W-1:0] bars,
    output logic                      frame_done,
    output logic                      frame_err
);

    localparam int unsigned IDX_W     = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int unsigned LVL_SHIFT = MAG_W - 5;
    localparam int unsigned LAST_IDX  = NUM_BARS - 1;

    typedef logic [NUM_BARS-1:0][BAR_W-1:0] bar_arr_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    bar_arr_t         shadow_q, shadow_d;
    bar_arr_t         bars_q, bars_d;
    bar_arr_t         swap_val;
    logic             mag_ready_q, mag_ready_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic             vsync_q, vsync_d;

    logic             xfer;
    logic             vsync_fall;
    logic             at_last_idx;
    logic [LVL_W-1:0] lvl_raw;
    logic [LVL_W-1:0] level;
    logic [BAR_W-1:0] mask;

    assign xfer        = mag_valid && mag_ready_q && (state_q == FILL);
    assign vsync_fall  = vsync_q && !vsync;
    assign at_last_idx = (idx_q == IDX_W'(LAST_IDX));

    // Quantise to 32 steps, then clamp to the number of physical segments.
    assign lvl_raw = LVL_W'(mag_data >> LVL_SHIFT);
    assign level   = (lvl_raw > LVL_W'(BAR_W)) ? LVL_W'(BAR_W) : lvl_raw;
    assign mask    = BAR_W'(level_to_mask(level));

`ifdef BAR_PEAK_HOLD_EN
    for (genvar g = 0; g < NUM_BARS; g++) begin : g_decay
        bar_level_decay #(
            .BAR_W (BAR_W)
        ) u_decay (
            .new_mask    (shadow_q[g]),
            .cur_mask    (bars_q[g]),
            .next_mask_c (swap_val[g])
        );
    end
`else
    assign swap_val = shadow_q;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        bars_d      = bars_q;
        frame_err_d = frame_err_q;
        vsync_d     = vsync;

        case (state_q)
            FILL: begin
                if (xfer) begin
                    // A short frame blanks every bar above the last one delivered.
                    for (int i = 0; i < int'(NUM_BARS); i++) begin
                        if (mag_last && (i > int'(idx_q))) begin
                            shadow_d[i] = '0;
                        end
                    end
                    shadow_d[idx_q] = mask;
                    if (at_last_idx && !mag_last) begin
                        frame_err_d = 1'b1;
                    end
                    if (at_last_idx || mag_last) begin
                        state_d = PEND;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PEND: begin
                if (vsync_fall) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                bars_d  = swap_val;
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        mag_ready_d  = (state_d == FILL);
        frame_done_d = (state_d == SWAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            idx_q        <= '0;
            shadow_q     <= '0;
            bars_q       <= '0;
            mag_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            vsync_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            bars_q       <= bars_d;
            mag_ready_q  <= mag_ready_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            vsync_q      <= vsync_d;
        end
    end

    assign mag_ready  = mag_ready_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign bars       = bars_q;

endmodule

// File: tb/tb_bar_frame_scheduler.sv
// Directed self-checking bench for bar_frame_scheduler (default build and BAR_PEAK_HOLD_EN build).
module tb_bar_frame_scheduler;

    localparam int unsigned NB = 16;
    localparam int unsigned BW = 18;
    localparam int unsigned MW = 12;
    localparam int unsigned TW = NB * BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          mag_valid;
    logic          mag_ready;
    logic [MW-1:0] mag_data;
    logic          mag_last;
    logic          vsync;
    logic [TW-1:0] bars;
    logic          frame_done;
    logic          frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    bar_frame_scheduler #(
        .NUM_BARS (NB),
        .BAR_W    (BW),
        .MAG_W    (MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mag_valid  (mag_valid),
        .mag_ready  (mag_ready),
        .mag_data   (mag_data),
        .mag_last   (mag_last),
        .vsync      (vsync),
        .bars       (bars),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Offer one sample at a negedge once ready is seen; it transfers on the next posedge.
    task automatic send(input logic [MW-1:0] d, input logic l);
        int n = 0;
        while (mag_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: mag_ready=%b after %0d cycles, required 1", mag_ready, n);
        end
        mag_valid = 1'b1;
        mag_data  = d;
        mag_last  = l;
        @(negedge clk);
        mag_valid = 1'b0;
        mag_last  = 1'b0;
    endtask

    // Drive one vsync falling edge and capture outputs one and two cycles later.
    task automatic vsync_fall(output int pulses, output logic fd1,
                              output logic [TW-1:0] bars1, output logic [TW-1:0] bars2);
        vsync = 1'b0;
        @(negedge clk);
        fd1    = frame_done;
        bars1  = bars;
        pulses = int'(frame_done);
        vsync  = 1'b1;
        @(negedge clk);
        bars2  = bars;
        pulses += int'(frame_done);
        repeat (3) begin
            @(negedge clk);
            pulses += int'(frame_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b1; mag_valid = 1'b0; mag_data = '0; mag_last = 1'b0;
        @(negedge clk);
        n_checks++; if (bars !== '0) begin n_fail++; $display("FAIL reset_bars: got %h required 0", bars); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
        n_checks++; if (mag_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", mag_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (mag_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b required 0", mag_ready); end
        @(negedge clk);
        n_checks++; if (mag_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b required 1", mag_ready); end
    endtask

    task automatic test_full_frame();
        int pulses; logic fd1; logic [TW-1:0] b1, b2, exp;
        exp = {NB{18'h3FFFF}};
        for (int i = 0; i < 16; i++) send(12'hFFF, (i == 15));
        n_checks++; if (mag_ready !== 1'b0) begin n_fail++; $display("FAIL full_pend_ready: got %b required 0", mag_ready); end
        n_checks++; if (bars !== '0) begin n_fail++; $display("FAIL full_bars_before_swap: got %h required 0", bars); end
        vsync_fall(pulses, fd1, b1, b2);
        n_checks++; if (fd1 !== 1'b1) begin n_fail++; $display("FAIL full_done_timing: got %b required 1", fd1); end
        n_checks++; if (b1 !== '0) begin n_fail++; $display("FAIL full_bars_early: got %h required 0", b1); end
        n_checks++; if (b2 !== exp) begin n_fail++; $display("FAIL full_bars: got %h required %h", b2, exp); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d required 1", pulses); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b required 0", frame_err); end
    endtask

    task automatic test_partial_frame();
        int pulses; logic fd1; logic [TW-1:0] b1, b2, exp;
        exp = '0;
        exp[1*BW +: BW] = 18'h00001;
        exp[2*BW +: BW] = 18'h00003;
        send(12'h000, 1'b0);
        send(12'h080, 1'b0);
        send(12'h100, 1'b1);
        vsync_fall(pulses, fd1, b1, b2);
        n_checks++; if (b1 !== {NB{18'h3FFFF}}) begin n_fail++; $display("FAIL partial_bars_early: got %h required all 3ffff", b1); end
        n_checks++; if (b2 !== exp) begin n_fail++; $display("FAIL partial_bars: got %h required %h", b2, exp); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL partial_done_pulses: got %0d required 1", pulses); end
    endtask

    task automatic test_vsync_in_fill();
        int pulses; logic fd1; logic [TW-1:0] b1, b2, prev;
        prev = bars;
        for (int i = 0; i < 5; i++) send(12'h200, 1'b0);
        vsync = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL fill_vsync_done: got %b required 0", frame_done); end
        end
        vsync = 1'b1;
        @(negedge clk);
        n_checks++; if (bars !== prev) begin n_fail++; $display("FAIL fill_vsync_bars: got %h required %h", bars, prev); end
        n_checks++; if (mag_ready !== 1'b1) begin n_fail++; $display("FAIL fill_vsync_ready: got %b required 1", mag_ready); end
        for (int i = 5; i < 16; i++) send(12'h200, (i == 15));
        n_checks++; if (mag_ready !== 1'b0) begin n_fail++; $display("FAIL fill_pend_ready: got %b required 0", mag_ready); end
        vsync_fall(pulses, fd1, b1, b2);
        n_checks++; if (b2 !== {NB{18'h0000F}}) begin n_fail++; $display("FAIL fill_latched_bars: got %h required all 0000f", b2); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL fill_done_pulses: got %0d required 1", pulses); end
    endtask

    task automatic test_stall();
        int pulses, n; logic fd1; logic [TW-1:0] b1, b2, exp, prev;
        prev = bars;
        exp  = '0;
        for (int i = 0; i < 16; i++) begin
            exp[i*BW +: BW] = BW'((32'd1 << i) - 32'd1);
            send(MW'(i << 7), (i == 15));
        end
        mag_valid = 1'b1; mag_data = 12'hFFF; mag_last = 1'b0;
        repeat (100) begin
            @(negedge clk);
            n_checks++; if (mag_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b required 0", mag_ready); end
        end
        n_checks++; if (bars !== prev) begin n_fail++; $display("FAIL stall_bars_held: got %h required %h", bars, prev); end
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        n = 0;
        while (mag_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (n >= 10) begin n_fail++; $display("FAIL stall_ready_timeout: mag_ready=%b required 1", mag_ready); end
        n_checks++; if (bars !== exp) begin n_fail++; $display("FAIL stall_bars: got %h required %h", bars, exp); end
        @(negedge clk);
        mag_valid = 1'b0;
        send(12'h080, 1'b1);
        exp = '0;
        exp[0*BW +: BW] = 18'h3FFFF;
        exp[1*BW +: BW] = 18'h00001;
        vsync_fall(pulses, fd1, b1, b2);
        n_checks++; if (b2 !== exp) begin n_fail++; $display("FAIL stall_held_sample: got %h required %h", b2, exp); end
    endtask

    task automatic test_no_last();
        int pulses; logic fd1; logic [TW-1:0] b1, b2;
        for (int i = 0; i < 15; i++) send(12'h180, 1'b0);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL nolast_err_early: got %b required 0", frame_err); end
        send(12'h180, 1'b0);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL nolast_err: got %b required 1", frame_err); end
        n_checks++; if (mag_ready !== 1'b0) begin n_fail++; $display("FAIL nolast_pend: got %b required 0", mag_ready); end
        vsync_fall(pulses, fd1, b1, b2);
        n_checks++; if (b2 !== {NB{18'h00007}}) begin n_fail++; $display("FAIL nolast_bars: got %h required all 00007", b2); end
        for (int i = 0; i < 16; i++) send(12'hFFF, (i == 15));
        vsync_fall(pulses, fd1, b1, b2);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL nolast_err_sticky: got %b required 1", frame_err); end
        n_checks++; if (b2 !== {NB{18'h3FFFF}}) begin n_fail++; $display("FAIL nolast_next_bars: got %h required all 3ffff", b2); end
    endtask

    task automatic test_reset_mid_frame();
        int pulses; logic fd1; logic [TW-1:0] b1, b2, exp;
        for (int i = 0; i < 3; i++) send(12'hFFF, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bars !== '0) begin n_fail++; $display("FAIL midrst_bars: got %h required 0", bars); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b required 0", frame_err); end
        n_checks++; if (mag_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b required 0", mag_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(12'h080, 1'b1);
        exp = '0;
        exp[0*BW +: BW] = 18'h00001;
        vsync_fall(pulses, fd1, b1, b2);
        n_checks++; if (b2 !== exp) begin n_fail++; $display("FAIL midrst_bar0: got %h required %h", b2, exp); end
    endtask

`ifdef BAR_PEAK_HOLD_EN
    task automatic test_peak_hold();
        int pulses; logic fd1; logic [TW-1:0] b1, b2, exp;
        logic [BW-1:0] want [3];
        logic [MW-1:0] din  [3];
        want[0] = 18'h3FFFF; want[1] = 18'h1FFFF; want[2] = 18'h0FFFF;
        din[0]  = 12'hFFF;   din[1]  = 12'h000;   din[2]  = 12'h000;
        for (int f = 0; f < 3; f++) begin
            send(din[f], 1'b1);
            vsync_fall(pulses, fd1, b1, b2);
            exp = '0;
            exp[0 +: BW] = want[f];
            n_checks++; if (b2 !== exp) begin n_fail++; $display("FAIL peak_frame%0d: got %h required %h", f, b2, exp); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef BAR_PEAK_HOLD_EN
        test_peak_hold();
`else
        test_full_frame();
        test_partial_frame();
        test_vsync_in_fill();
        test_stall();
        test_no_last();
        test_reset_mid_frame();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bar_frame_scheduler.md
BAR_FRAME_SCHEDULER -- requirements
Module: bar_frame_scheduler

Interface
REQ-001 Parameter NUM_BARS, default 16: number of spectrum bars driven to the display.
REQ-002 Parameter BAR_W, default 18: segments per bar, i.e. bit width of one bar mask.
REQ-003 Parameter MAG_W, default 12: width of each input magnitude sample.
REQ-004 Port clk, input, 1: single clock for the whole block (pixel clock domain).
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port mag_valid, input, 1: a magnitude sample is offered.
REQ-007 Port mag_ready, output, 1: block accepts the sample this cycle.
REQ-008 Port mag_data, input, MAG_W: unsigned magnitude for the current bar index.
REQ-009 Port mag_last, input, 1: marks the final sample of a frame.
REQ-010 Port vsync, input, 1: active-low vertical sync from the display timing, already in the clk domain.
REQ-011 Port bars, output, NUM_BARS*BAR_W: display bar masks; bar i occupies bits [i*BAR_W +: BAR_W].
REQ-012 Port frame_done, output, 1: one-cycle pulse when a new frame is latched to bars.
REQ-013 Port frame_err, output, 1: sticky flag for a malformed frame, cleared only by reset.

Function
REQ-014 The FSM SHALL have exactly three states: FILL, PEND and SWAP.
REQ-015 In FILL, mag_ready SHALL be 1; a transfer occurs when mag_valid && mag_ready.
REQ-016 Each transfer SHALL write the converted mask into shadow[idx], then increment idx (width clog2(NUM_BARS)).
REQ-017 Conversion: level = mag_data >> (MAG_W-5), clamped to BAR_W; mask = (1<<level)-1, with bit 0 as the bottom segment.
REQ-018 A transfer with idx==NUM_BARS-1, or with mag_last set, SHALL move FILL->PEND and reset idx to 0.
REQ-019 If mag_last arrives with idx<NUM_BARS-1, shadow entries idx+1..NUM_BARS-1 SHALL be written to 0.
REQ-020 A transfer at idx==NUM_BARS-1 without mag_last SHALL set frame_err, and the frame is still accepted.
REQ-021 In PEND and SWAP, mag_ready SHALL be 0.
REQ-022 vsync falling edge: detected by a registered copy of vsync, i.e. vsync_q==1 && vsync==0.
REQ-023 In PEND, a falling edge SHALL move the FSM to SWAP on the next cycle.
REQ-024 In SWAP, for one cycle, shadow SHALL be copied to bars, frame_done SHALL be 1, and the FSM SHALL return to FILL.
REQ-025 Latency: bars change exactly 2 clk cycles after the vsync falling-edge sample cycle.
REQ-026 A vsync edge seen during FILL SHALL be ignored; bars hold the previous frame (no tearing, no partial frames).
REQ-027 mag_valid during PEND or SWAP SHALL be stalled; upstream holds the data.
REQ-028 bars SHALL change only in SWAP.

Reset
REQ-029 On rst assertion, outputs SHALL immediately take these values: bars=0, frame_done=0, frame_err=0, mag_ready=0.
REQ-030 On rst assertion, internal state SHALL immediately reset: shadow=0, idx=0, vsync_q=1, state=FILL.
REQ-031 mag_ready SHALL rise to 1 on the first clk edge after rst deasserts.
REQ-032 Reset mid-frame SHALL discard the partial shadow; the next accepted sample is bar 0.

Configuration
REQ-033 Macro BAR_PEAK_HOLD_EN: when defined, SWAP SHALL compare the shadow level with the current bar level per bar.
REQ-034 With BAR_PEAK_HOLD_EN, a new level >= the current level SHALL be loaded; a lower level SHALL make the displayed level decrease by 1 per SWAP, never below the new level.
REQ-035 Without BAR_PEAK_HOLD_EN, SWAP SHALL copy shadow to bars directly, with no extra state.

Structure
REQ-036 Package bar_pkg SHALL hold NUM_BARS, BAR_W, MAG_W defaults, the FSM state enum, and a level-to-mask function.
REQ-037 Sub-module bar_level_decay SHALL implement one bar's peak-hold compare/decay, instantiated NUM_BARS times and present only under BAR_PEAK_HOLD_EN.

Verification
REQ-038 Send 16 samples 0xFFF..., last on the 16th, then a vsync fall -> every bar = 0x3FFFF, one frame_done pulse, frame_err=0.
REQ-039 Send samples 0x000,0x080,0x100 with last on the 3rd -> bar0=0, bar1=0x1, bar2=0x3, bars3-15=0.
REQ-040 Send 16 samples without last -> frame_err=1 and stays 1; the frame is still displayed after vsync.
REQ-041 Drive a vsync fall mid-FILL -> bars unchanged; mag_ready stays 1; after completion the next vsync latches the frame.
REQ-042 Hold mag_valid in PEND for 100 cycles -> mag_ready=0, no data loss, and the first sample after SWAP lands in bar 0.
REQ-043 With BAR_PEAK_HOLD_EN, bar0 levels 18,0,0 on successive frames -> displayed bar0 = 0x3FFFF, 0x1FFFF, 0x0FFFF.
